ps2_keyboard_rx: RTL and testbench

- PS/2 keyboard receiver sitting directly downstream of the board PS2_CLK/PS2_DATA pins, inside TOP.
- Feeds the keyboard-matrix/scancode translation logic.
- Synchronises and deglitches the PS/2 lines, deserialises 11-bit device-to-host frames, and checks start, odd parity and stop bits.
- Folds E0/F0 prefixes into flags and emits one strobed key event per make/break code.

---
 rtl/ps2_keyboard_rx.sv | 197 +++++++++++++++++++
 tb/tb_ps2_keyboard_rx.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_rx.sv
// ---------------------------------------------------------------------------
// ps2_keyboard_rx
// PS/2 keyboard receiver. Synchronises and deglitches the raw PS/2 lines,
// deserialises 11-bit device-to-host frames (start, 8 data LSB first, odd
// parity, stop), folds E0/F0 prefixes into flags and strobes one key event
// per make/break code.
//
// Ports:
//   CLK100MHZ   system clock, all logic on the rising edge
//   CPU_RESETN  asynchronous active-low reset
//   PS2_CLK     raw keyboard clock (asynchronous)
//   PS2_DATA    raw keyboard data (asynchronous)
//   KEY_CODE    last completed scancode, prefixes stripped
//   KEY_EXT     KEY_CODE was preceded by E0
//   KEY_BREAK   KEY_CODE was preceded by F0 (release)
//   KEY_VALID   one-cycle strobe, key outputs held until the next strobe
//   FRAME_ERR   one-cycle strobe on start/parity/stop/timeout error
// ---------------------------------------------------------------------------
module ps2_keyboard_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       CLK100MHZ,
    input  logic       CPU_RESETN,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] KEY_CODE,
    output logic       KEY_EXT,
    output logic       KEY_BREAK,
    output logic       KEY_VALID,
    output logic       FRAME_ERR
);
    localparam int FCW = $clog2(FILTER_LEN + 1);
    localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FCW-1:0] FILT_LAST = FCW'(FILTER_LEN - 1);
    localparam logic [TW-1:0]  TO_MAX    = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    // Synchronisers and filter sit at 1 in reset: an idle bus must not
    // look like a falling edge when reset is released.
    logic           clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
    logic           clk_filt_q, clk_filt_d, clk_prev_q;
    logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
    logic           fall;

    state_t         state_q, state_d;
    logic [2:0]     bitcnt_q, bitcnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           parity_ok_q, parity_ok_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic           to_hit;
    logic           ext_pend_q, ext_pend_d, break_pend_q, break_pend_d;
    logic [7:0]     key_code_q, key_code_d;
    logic           key_ext_q, key_ext_d, key_break_q, key_break_d;
    logic           key_valid_q, key_valid_d, frame_err_q, frame_err_d;

    // CLK filter: the level flips only on the FILTER_LEN-th consecutive
    // sample that disagrees with it; any agreeing sample restarts the count.
    always_comb begin
        clk_filt_d = clk_filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != clk_filt_q) begin
            if (filt_cnt_q == FILT_LAST) begin
                clk_filt_d = clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    assign fall   = clk_prev_q & ~clk_filt_q;
    assign to_hit = (to_cnt_q >= TO_MAX);

    always_comb begin
        state_d      = state_q;
        bitcnt_d     = bitcnt_q;
        shift_d      = shift_q;
        parity_ok_d  = parity_ok_q;
        ext_pend_d   = ext_pend_q;
        break_pend_d = break_pend_q;
        key_code_d   = key_code_q;
        key_ext_d    = key_ext_q;
        key_break_d  = key_break_q;
        key_valid_d  = 1'b0;
        frame_err_d  = 1'b0;

        // Saturating timeout, only meaningful mid-frame.
        if (fall || state_q == IDLE) begin
            to_cnt_d = '0;
        end else if (!to_hit) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end else begin
            to_cnt_d = to_cnt_q;
        end

        // A fall in the same cycle as the timeout takes priority.
        if (fall) begin
            unique case (state_q)
                IDLE: begin
                    if (!data_s2_q) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d  = {data_s2_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 1'b1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    parity_ok_d = (^shift_q) ^ data_s2_q;
                    state_d     = STOP;
                end
                STOP: begin
                    state_d = IDLE;
                    if (data_s2_q && parity_ok_q) begin
                        if (shift_q == 8'hF0) begin
                            break_pend_d = 1'b1;
                        end else if (shift_q == 8'hE0) begin
                            ext_pend_d = 1'b1;
                        end else begin
                            key_code_d   = shift_q;
                            key_ext_d    = ext_pend_q;
                            key_break_d  = break_pend_q;
                            key_valid_d  = 1'b1;
                            ext_pend_d   = 1'b0;
                            break_pend_d = 1'b0;
                        end
                    end else begin
                        frame_err_d  = 1'b1;
                        ext_pend_d   = 1'b0;
                        break_pend_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && to_hit) begin
            state_d      = IDLE;
            frame_err_d  = 1'b1;
            ext_pend_d   = 1'b0;
            break_pend_d = 1'b0;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            clk_s1_q     <= 1'b1;
            clk_s2_q     <= 1'b1;
            data_s1_q    <= 1'b1;
            data_s2_q    <= 1'b1;
            clk_filt_q   <= 1'b1;
            clk_prev_q   <= 1'b1;
            filt_cnt_q   <= '0;
            state_q      <= IDLE;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            parity_ok_q  <= 1'b0;
            to_cnt_q     <= '0;
            ext_pend_q   <= 1'b0;
            break_pend_q <= 1'b0;
            key_code_q   <= '0;
            key_ext_q    <= 1'b0;
            key_break_q  <= 1'b0;
            key_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_s1_q     <= PS2_CLK;
            clk_s2_q     <= clk_s1_q;
            data_s1_q    <= PS2_DATA;
            data_s2_q    <= data_s1_q;
            clk_filt_q   <= clk_filt_d;
            clk_prev_q   <= clk_filt_q;
            filt_cnt_q   <= filt_cnt_d;
            state_q      <= state_d;
            bitcnt_q     <= bitcnt_d;
            shift_q      <= shift_d;
            parity_ok_q  <= parity_ok_d;
            to_cnt_q     <= to_cnt_d;
            ext_pend_q   <= ext_pend_d;
            break_pend_q <= break_pend_d;
            key_code_q   <= key_code_d;
            key_ext_q    <= key_ext_d;
            key_break_q  <= key_break_d;
            key_valid_q  <= key_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign KEY_CODE  = key_code_q;
    assign KEY_EXT   = key_ext_q;
    assign KEY_BREAK = key_break_q;
    assign KEY_VALID = key_valid_q;
    assign FRAME_ERR = frame_err_q;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_keyboard_rx
// Directed PS/2 frames with hand-computed expected events. Stimulus pushes
// expected events into a queue; the monitor pops and compares on every
// KEY_VALID / FRAME_ERR strobe.
// ---------------------------------------------------------------------------
module tb_ps2_keyboard_rx;
    localparam int FL = 8;
    localparam int TO = 2000;
    localparam int HP = 20;   // PS/2 half bit period in system cycles

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] key_code;
    logic       key_ext, key_break, key_valid, frame_err;

    ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .CLK100MHZ (clk),
        .CPU_RESETN(rst_n),
        .PS2_CLK   (ps2_clk),
        .PS2_DATA  (ps2_data),
        .KEY_CODE  (key_code),
        .KEY_EXT   (key_ext),
        .KEY_BREAK (key_break),
        .KEY_VALID (key_valid),
        .FRAME_ERR (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       err;
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    ev_t exp_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_key(input logic [7:0] c, input logic e, input logic b);
        ev_t ev;
        ev.err = 1'b0; ev.code = c; ev.ext = e; ev.brk = b;
        exp_q.push_back(ev);
    endtask

    task automatic push_err();
        ev_t ev;
        ev.err = 1'b1; ev.code = '0; ev.ext = 1'b0; ev.brk = 1'b0;
        exp_q.push_back(ev);
    endtask

    // Data changes in the high phase; optional short low glitch on CLK
    // (FL-1 cycles) precedes the real falling edge.
    task automatic ps2_bit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            wait_cyc(5);
            ps2_clk = 1'b0;
            wait_cyc(FL - 1);
            ps2_clk = 1'b1;
            wait_cyc(HP - 5 - (FL - 1));
        end else begin
            wait_cyc(HP);
        end
        ps2_clk = 1'b0;
        wait_cyc(HP);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par = 1'b0,
                              input bit bad_stop = 1'b0, input bit glitch = 1'b0);
        ps2_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
        ps2_bit((~^b) ^ bad_par, glitch);
        ps2_bit(~bad_stop, glitch);
        ps2_data = 1'b1;
        wait_cyc(HP);
    endtask

    task automatic check_outs_zero(input string name);
        logic [11:0] got;
        got = {key_code, key_ext, key_break, key_valid, frame_err};
        n_tests++;
        if (got != 12'h000) begin
            n_fail++;
            $display("FAIL %s: outputs got %h want 000", name, got);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n && (key_valid || frame_err)) begin
            n_tests++;
            if (key_valid && frame_err) begin
                n_fail++;
                $display("FAIL both_strobes: KEY_VALID and FRAME_ERR together, code %h", key_code);
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: valid=%b err=%b code=%h ext=%b brk=%b, none expected",
                         key_valid, frame_err, key_code, key_ext, key_break);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.err) begin
                    if (!frame_err) begin
                        n_fail++;
                        $display("FAIL event: got key code=%h ext=%b brk=%b, want FRAME_ERR",
                                 key_code, key_ext, key_break);
                    end
                end else if (!key_valid || key_code != e.code ||
                             key_ext != e.ext || key_break != e.brk) begin
                    n_fail++;
                    $display("FAIL event: got valid=%b code=%h ext=%b brk=%b, want code=%h ext=%b brk=%b",
                             key_valid, key_code, key_ext, key_break, e.code, e.ext, e.brk);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        wait_cyc(5);
        check_outs_zero("reset_state");
        rst_n = 1'b1;
        wait_cyc(20);

        // Plain make code
        push_key(8'h1C, 1'b0, 1'b0); send_frame(8'h1C);
        // Break: F0 1C, then make 1C with flags cleared
        send_frame(8'hF0);
        push_key(8'h1C, 1'b0, 1'b1); send_frame(8'h1C);
        push_key(8'h1C, 1'b0, 1'b0); send_frame(8'h1C);
        // Extended break
        send_frame(8'hE0);
        send_frame(8'hF0);
        push_key(8'h75, 1'b1, 1'b1); send_frame(8'h75);
        // Parity error, then good frame
        push_err(); send_frame(8'h3A, 1'b1);
        push_key(8'h44, 1'b0, 1'b0); send_frame(8'h44);
        // Stop error clears a pending F0
        send_frame(8'hF0);
        push_err(); send_frame(8'h29, 1'b0, 1'b1);
        push_key(8'h1C, 1'b0, 1'b0); send_frame(8'h1C);
        // Special bytes passed through as codes
        push_key(8'hE1, 1'b0, 1'b0); send_frame(8'hE1);
        push_key(8'hAA, 1'b0, 1'b0); send_frame(8'hAA);
        // False start: fall with data high while idle
        push_err(); ps2_bit(1'b1, 1'b0); wait_cyc(HP);
        // Timeout after start + 3 data bits
        push_err();
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) ps2_bit(1'b1, 1'b0);
        ps2_data = 1'b1;
        wait_cyc(TO + 10);
        push_key(8'h5A, 1'b0, 1'b0); send_frame(8'h5A);
        // Glitches between every bit
        push_key(8'h2B, 1'b0, 1'b0); send_frame(8'h2B, 1'b0, 1'b0, 1'b1);
        // Reset mid-frame
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_outs_zero("midframe_reset");
        wait_cyc(5);
        rst_n = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(HP);
        push_key(8'h1B, 1'b0, 1'b0); send_frame(8'h1B);

        wait_cyc(50);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: %0d expected events not seen, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
